// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer: a DEPTH-entry FIFO of pending stores in front of a 256x32 single-port array.
// Build option SB_FORWARD_EN: loads hitting a pending store get the youngest entry's data instead of stalling.
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_we,
    input  logic        dmem_re,
    input  logic [9:0]  dmem_addr,
    input  logic [31:0] dmem_wd,
    output logic [31:0] dmem_rd,
    output logic        dmem_stall,
    output logic [3:0]  sb_count,
    output logic        sb_empty
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [31:0]   mem       [256];
    logic [7:0]    fifo_idx  [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [3:0]    count;

    logic [7:0]    load_idx;
    logic          match;
    logic          load_stall;
    logic          full_stall;
    logic          port_free;
    logic          enq;
    logic          drain;
    logic          unused_addr_lsbs;

    assign load_idx         = dmem_addr[9:2];
    assign unused_addr_lsbs = ^dmem_addr[1:0];

`ifdef SB_FORWARD_EN
    logic [31:0] fwd_data;

    // Scan oldest to youngest so the last hit leaves the youngest entry's data.
    always_comb begin
        match    = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (4'(i) < count && fifo_idx[head + PW'(i)] == load_idx) begin
                match    = 1'b1;
                fwd_data = fifo_data[head + PW'(i)];
            end
        end
    end

    assign load_stall = 1'b0;
`else
    always_comb begin
        match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (4'(i) < count && fifo_idx[head + PW'(i)] == load_idx) begin
                match = 1'b1;
            end
        end
    end

    assign load_stall = dmem_re && match;
`endif

    assign full_stall = dmem_we && (count == DEPTH_C);
    assign dmem_stall = full_stall || load_stall;
    // A stalled load gives up the array port so the matching entries can drain.
    assign port_free  = !dmem_re || load_stall;
    assign enq        = dmem_we && (count < DEPTH_C);
    assign drain      = (count != 4'd0) && port_free;

    always_comb begin
        dmem_rd = '0;
        if (dmem_re && !reset) begin
            dmem_rd = mem[load_idx];
`ifdef SB_FORWARD_EN
            if (match) begin
                dmem_rd = fwd_data;
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            case ({enq, drain})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the reset term suppresses writes on an edge that coincides with reset.
    always_ff @(posedge clock) begin
        if (enq && !reset) begin
            fifo_idx[tail]  <= load_idx;
            fifo_data[tail] <= dmem_wd;
        end
        if (drain && !reset) begin
            mem[fifo_idx[head]] <= fifo_data[head];
        end
    end

    assign sb_count = count;
    assign sb_empty = (count == 4'd0);

endmodule
